mem_refill_arbiter: RTL and testbench

Shares the single memory read port between the instruction cache and the data cache for refill requests. It arbitrates round-robin, allocates one transaction ID from a pool of 2^MemTidWidth per accepted request, and tracks outstanding IDs. Each response is routed back to the requester that owns its ID. The block sits between the cache miss handlers and the NoC adapter, and is sized by the core's MemTidWidth and AxiAddrWidth settings.

---
 rtl/mem_refill_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_refill_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter
//
// Shares one memory read port between the icache and dcache refill paths.
// Requests are arbitrated round-robin, each accepted request takes the
// lowest free transaction ID from a pool of 2^TidWidth, and every response
// is routed back to the requester that owns its ID.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          synchronous active-low reset
//   req_valid_i     per-requester refill request valid
//   req_addr_i      per-requester refill address
//   req_ready_o     per-requester accept strobe (one-hot or zero, combinational)
//   mem_valid_o     outbound request valid (registered)
//   mem_ready_i     downstream accepts the outbound request
//   mem_addr_o      outbound address (registered)
//   mem_tid_o       allocated transaction ID (registered)
//   mem_src_o       index of the originating requester (registered)
//   rsp_valid_i     final response beat valid, frees its ID
//   rsp_tid_i       ID of the response
//   rsp_valid_o     routed response valid, one-hot (combinational)
//   outstanding_o   number of busy IDs (registered)
//   protocol_err_o  sticky: a response arrived for an ID that was not busy
module mem_refill_arbiter #(
    parameter int NrReq     = 2,
    parameter int AddrWidth = 64,
    parameter int TidWidth  = 2,
    localparam int SrcWidth = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrReq-1:0]                  req_valid_i,
    input  logic [NrReq-1:0][AddrWidth-1:0]   req_addr_i,
    output logic [NrReq-1:0]                  req_ready_o,
    output logic                              mem_valid_o,
    input  logic                              mem_ready_i,
    output logic [AddrWidth-1:0]              mem_addr_o,
    output logic [TidWidth-1:0]               mem_tid_o,
    output logic [SrcWidth-1:0]               mem_src_o,
    input  logic                              rsp_valid_i,
    input  logic [TidWidth-1:0]               rsp_tid_i,
    output logic [NrReq-1:0]                  rsp_valid_o,
    output logic [TidWidth:0]                 outstanding_o,
    output logic                              protocol_err_o
);

    localparam int NrTid    = 1 << TidWidth;
    localparam int CntWidth = TidWidth + 1;

    logic [NrTid-1:0]                busy_q;
    logic [NrTid-1:0]                busy_d;
    logic [NrTid-1:0][SrcWidth-1:0]  owner_q;
    logic [SrcWidth-1:0]             rr_q;

    logic                            out_free;
    logic                            any_free;
    logic                            winner_found;
    logic [SrcWidth-1:0]             winner;
    logic [TidWidth-1:0]             free_tid;
    logic                            grant;
    logic                            rsp_hit;

    // Search offsets from the highest down so the last match is the one
    // closest to rr_q going upward with wrap.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        for (int k = NrReq - 1; k >= 0; k--) begin
            for (int j = 0; j < NrReq; j++) begin
                if (j == (int'(rr_q) + k) % NrReq && req_valid_i[j]) begin
                    winner       = SrcWidth'(j);
                    winner_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        free_tid = '0;
        for (int t = NrTid - 1; t >= 0; t--) begin
            if (!busy_q[t]) begin
                free_tid = TidWidth'(t);
            end
        end
    end

    assign any_free = ~&busy_q;
    assign out_free = !mem_valid_o || mem_ready_i;
    assign grant    = rst_ni && out_free && any_free && winner_found;
    assign rsp_hit  = rst_ni && rsp_valid_i && busy_q[rsp_tid_i];

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        for (int j = 0; j < NrReq; j++) begin
            req_ready_o[j] = grant && (winner == SrcWidth'(j));
            rsp_valid_o[j] = rsp_hit && (owner_q[rsp_tid_i] == SrcWidth'(j));
        end
    end

    // The freed ID was busy and the allocated one was not, so the two
    // updates never touch the same bit.
    always_comb begin
        busy_d = busy_q;
        if (rsp_hit) begin
            busy_d[rsp_tid_i] = 1'b0;
        end
        if (grant) begin
            busy_d[free_tid] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q         <= '0;
            owner_q        <= '0;
            rr_q           <= '0;
            mem_valid_o    <= 1'b0;
            mem_addr_o     <= '0;
            mem_tid_o      <= '0;
            mem_src_o      <= '0;
            outstanding_o  <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            outstanding_o <= CntWidth'($countones(busy_d));

            if (grant) begin
                owner_q[free_tid] <= winner;
                mem_valid_o       <= 1'b1;
                mem_addr_o        <= req_addr_i[winner];
                mem_tid_o         <= free_tid;
                mem_src_o         <= winner;
                rr_q              <= (int'(winner) == NrReq - 1) ? '0 : winner + 1'b1;
            end else if (mem_ready_i) begin
                mem_valid_o <= 1'b0;
            end

            if (rsp_valid_i && !busy_q[rsp_tid_i]) begin
                protocol_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
module tb_mem_refill_arbiter;

    localparam int NR = 2;
    localparam int AW = 64;
    localparam int TW = 2;
    localparam int NT = 1 << TW;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic [NR-1:0]            req_valid_i;
    logic [NR-1:0][AW-1:0]    req_addr_i;
    logic [NR-1:0]            req_ready_o;
    logic                     mem_valid_o;
    logic                     mem_ready_i;
    logic [AW-1:0]            mem_addr_o;
    logic [TW-1:0]            mem_tid_o;
    logic [0:0]               mem_src_o;
    logic                     rsp_valid_i;
    logic [TW-1:0]            rsp_tid_i;
    logic [NR-1:0]            rsp_valid_o;
    logic [TW:0]              outstanding_o;
    logic                     protocol_err_o;

    mem_refill_arbiter #(.NrReq(NR), .AddrWidth(AW), .TidWidth(TW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_addr_i     (req_addr_i),
        .req_ready_o    (req_ready_o),
        .mem_valid_o    (mem_valid_o),
        .mem_ready_i    (mem_ready_i),
        .mem_addr_o     (mem_addr_o),
        .mem_tid_o      (mem_tid_o),
        .mem_src_o      (mem_src_o),
        .rsp_valid_i    (rsp_valid_i),
        .rsp_tid_i      (rsp_tid_i),
        .rsp_valid_o    (rsp_valid_o),
        .outstanding_o  (outstanding_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: ID pool as a flag array, owner per ID, pointer as int
    bit          m_busy [NT];
    int          m_owner[NT];
    int          m_rr;
    bit          m_vld;
    logic [63:0] m_addr;
    int          m_tid;
    int          m_src;
    bit          m_perr;
    logic [NR-1:0] last_ready;

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < NT; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_busy[i]  = 1'b0;
            m_owner[i] = 0;
        end
        m_rr = 0; m_vld = 0; m_addr = '0; m_tid = 0; m_src = 0; m_perr = 0;
    endtask

    // One clock cycle: called just after a falling edge.
    task automatic cyc(input bit rst, input bit [1:0] v, input logic [63:0] a0,
                       input logic [63:0] a1, input bit mr, input bit rv, input int rt);
        bit grant, hit;
        int win, gtid, nfree;
        logic [63:0] addrs[2];
        chk("mem_valid", 64'(mem_valid_o), 64'(m_vld));
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_tid", 64'(mem_tid_o), 64'(m_tid));
        chk("mem_src", 64'(mem_src_o), 64'(m_src));
        chk("outstanding", 64'(outstanding_o), 64'(busy_count()));
        chk("protocol_err", 64'(protocol_err_o), 64'(m_perr));

        rst_ni      = rst;
        req_valid_i = v;
        req_addr_i[0] = a0;
        req_addr_i[1] = a1;
        addrs[0] = a0;
        addrs[1] = a1;
        mem_ready_i = mr;
        rsp_valid_i = rv;
        rsp_tid_i   = TW'(rt);
        #1;

        nfree = NT - busy_count();
        win = -1;
        for (int k = 0; k < NR; k++) begin
            if (win < 0 && v[(m_rr + k) % NR]) win = (m_rr + k) % NR;
        end
        grant = rst && (!m_vld || mr) && nfree > 0 && win >= 0;
        gtid = -1;
        for (int i = 0; i < NT; i++) begin
            if (gtid < 0 && !m_busy[i]) gtid = i;
        end
        hit = rst && rv && m_busy[rt];

        last_ready = req_ready_o;
        chk("req_ready", 64'(req_ready_o), grant ? 64'(1) << win : 64'(0));
        chk("rsp_valid", 64'(rsp_valid_o), hit ? 64'(1) << m_owner[rt] : 64'(0));

        @(posedge clk_i);
        if (!rst) begin
            model_reset();
        end else begin
            if (rv) begin
                if (m_busy[rt]) m_busy[rt] = 1'b0;
                else m_perr = 1'b1;
            end
            if (m_vld && mr) m_vld = 1'b0;
            if (grant) begin
                m_busy[gtid]  = 1'b1;
                m_owner[gtid] = win;
                m_vld  = 1'b1;
                m_addr = addrs[win];
                m_tid  = gtid;
                m_src  = win;
                m_rr   = (win + 1) % NR;
            end
        end
        @(negedge clk_i);
    endtask

    function automatic logic [63:0] raddr();
        return {$urandom, $urandom};
    endfunction

    task automatic do_reset();
        cyc(0, 2'b00, '0, '0, 0, 0, 0);
    endtask

    logic [63:0] s_addr;
    int          s_tid, s_src;

    initial begin
        rst_ni = 0; req_valid_i = '0; req_addr_i = '0; mem_ready_i = 0;
        rsp_valid_i = 0; rsp_tid_i = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        model_reset();

        // reset with toggling inputs, then first request from requester 1
        for (int i = 0; i < 6; i++)
            cyc(0, 2'($urandom), raddr(), raddr(), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        cyc(1, 2'b10, raddr(), 64'h8000_0040, 1, 0, 0);
        chk("tp1_valid", 64'(mem_valid_o), 64'd1);
        chk("tp1_tid", 64'(mem_tid_o), 64'd0);
        chk("tp1_src", 64'(mem_src_o), 64'd1);
        chk("tp1_addr", mem_addr_o, 64'h8000_0040);

        // both requesters continuously, immediate responses: 0,1,0,1...
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1, 2'b11, raddr(), raddr(), 1, i > 0, int'(mem_tid_o));
            chk("tp2_src", 64'(mem_src_o), 64'(i % 2));
        end

        // pool exhaustion, then reuse of a freed ID
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 2'b01, raddr(), raddr(), 1, 0, 0);
        chk("tp3_out4", 64'(outstanding_o), 64'd4);
        cyc(1, 2'b01, raddr(), raddr(), 1, 0, 0);
        chk("tp3_stall", 64'(last_ready), 64'd0);
        cyc(1, 2'b01, raddr(), raddr(), 1, 1, 2);
        chk("tp3_nogrant", 64'(last_ready), 64'd0);
        cyc(1, 2'b01, raddr(), raddr(), 1, 0, 0);
        chk("tp3_tid2", 64'(mem_tid_o), 64'd2);

        // backpressure holds the output register
        do_reset();
        cyc(1, 2'b01, raddr(), raddr(), 0, 0, 0);
        s_addr = mem_addr_o; s_tid = int'(mem_tid_o); s_src = int'(mem_src_o);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 2'b11, raddr(), raddr(), 0, 0, 0);
            chk("tp4_hold_ready", 64'(last_ready), 64'd0);
        end
        chk("tp4_addr", mem_addr_o, s_addr);
        chk("tp4_tid", 64'(mem_tid_o), 64'(s_tid));
        chk("tp4_src", 64'(mem_src_o), 64'(s_src));
        cyc(1, 2'b11, raddr(), raddr(), 1, 0, 0);
        chk("tp4_regrant", 64'(last_ready), 64'b10);

        // response to an idle ID
        do_reset();
        cyc(1, 2'b00, '0, '0, 1, 1, 3);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 2'b00, '0, '0, 1, 0, 0);
            chk("tp5_perr", 64'(protocol_err_o), 64'd1);
        end
        do_reset();
        chk("tp5_cleared", 64'(protocol_err_o), 64'd0);

        // response and grant in the same cycle
        do_reset();
        cyc(1, 2'b01, raddr(), raddr(), 1, 0, 0);
        cyc(1, 2'b10, raddr(), raddr(), 1, 1, 0);
        chk("tp6_rsp", 64'(rsp_valid_o === 2'b00), 64'd1);
        chk("tp6_tid", 64'(mem_tid_o), 64'd1);
        chk("tp6_src", 64'(mem_src_o), 64'd1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int  rt;
            bit  rv;
            int  nb;
            int  pick;
            rt = int'($urandom_range(0, NT - 1));
            rv = ($urandom_range(0, 9) < 4);
            if (rv && $urandom_range(0, 19) != 0) begin
                nb = busy_count();
                if (nb == 0) rv = 0;
                else begin
                    pick = int'($urandom_range(0, nb - 1));
                    for (int i = 0; i < NT; i++) begin
                        if (m_busy[i]) begin
                            if (pick == 0) rt = i;
                            pick--;
                        end
                    end
                end
            end
            cyc($urandom_range(0, 63) != 0, 2'($urandom), raddr(), raddr(),
                $urandom_range(0, 3) != 0, rv, rt);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
